// File: rtl/de2i_150_qsys_led_bank_if.sv
// Avalon-MM slave bundle for the LED bank.
// Address width is the bank's word address width.
interface de2i_150_qsys_led_bank_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write_n;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address,
        output chipselect,
        output read,
        output write_n,
        output byteenable,
        output writedata,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write_n,
        input  byteenable,
        input  writedata,
        output readdata,
        output readdatavalid
    );
endinterface

// File: rtl/de2i_150_qsys_led_bank.sv
// Multi-channel LED/output register bank on Avalon-MM with
// set/clear writes, byte enables and a shared blink generator.
module de2i_150_qsys_led_bank #(
    parameter int               NUM_CH    = 4,
    parameter int               WIDTH     = 9,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               BLINK_DIV = 25000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    de2i_150_qsys_led_bank_if.slave bus,
    output logic [NUM_CH*WIDTH-1:0] out_port
);
    localparam int ADDR_W = $clog2(NUM_CH) + 2;
    localparam int CH_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int CNT_W  = $clog2(BLINK_DIV);

    logic [WIDTH-1:0] r_data  [NUM_CH];
    logic [WIDTH-1:0] r_blink [NUM_CH];
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic [31:0]      r_rdata;
    logic             r_rvalid;

    logic [CH_W-1:0]  w_ch;
    logic [1:0]       w_reg;
    logic             w_wr;
    logic             w_rd;
    logic [31:0]      w_mask32;
    logic [31:0]      w_wd32;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_rsel;
    logic             w_unused;

    generate
        if (ADDR_W > 2) begin : g_ch
            assign w_ch = bus.address[ADDR_W-1:2];
        end else begin : g_ch1
            assign w_ch = '0;
        end
    endgenerate

    assign w_reg = bus.address[1:0];
    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_rd  = bus.chipselect & bus.read & bus.write_n;

    assign w_mask32 = {{8{bus.byteenable[3]}},
                       {8{bus.byteenable[2]}},
                       {8{bus.byteenable[1]}},
                       {8{bus.byteenable[0]}}};
    // Disabled lanes read as zero, so SET/CLEAR leave those bits alone
    assign w_wd32   = bus.writedata & w_mask32;
    assign w_mask   = w_mask32[WIDTH-1:0];
    assign w_wd     = w_wd32[WIDTH-1:0];
    assign w_unused = &{1'b0, w_wd32, w_mask32};

    // Out-of-range channels match no c, so their writes fall away
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_data[c]  <= RESET_VAL;
                r_blink[c] <= '0;
            end
        end else if (w_wr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch == CH_W'(c)) begin
                    unique case (w_reg)
                        2'd0: r_data[c]  <= (r_data[c] & ~w_mask) | w_wd;
                        2'd1: r_data[c]  <= r_data[c] | w_wd;
                        2'd2: r_data[c]  <= r_data[c] & ~w_wd;
                        2'd3: r_blink[c] <= (r_blink[c] & ~w_mask) | w_wd;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rsel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == CH_W'(c)) begin
                w_rsel = (w_reg == 2'd3) ? r_blink[c] : r_data[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= 32'(w_rsel);
            end
        end
    end

    assign bus.readdata      = r_rdata;
    assign bus.readdatavalid = r_rvalid;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_out
            assign out_port[c*WIDTH +: WIDTH] =
                r_data[c] & ~(r_blink[c] & {WIDTH{r_phase}});
        end
    endgenerate
endmodule

// File: tb/tb_de2i_150_qsys_led_bank.sv
// Directed bench for the LED bank: register map, byte lanes,
// read pipeline, blink timing and mid-operation reset.
module tb_de2i_150_qsys_led_bank;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 9;
    localparam int ADDR_W = 4;

    typedef struct {
        logic [1:0]  ch;
        logic [1:0]  rg;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [8:0]  exp;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_CH*WIDTH-1:0] out_port;
    int                      n_chk = 0;
    int                      n_err = 0;
    vec_t                    tbl [12];
    logic [8:0]              pexp [4];

    de2i_150_qsys_led_bank_if #(.ADDR_W(ADDR_W)) bus ();

    de2i_150_qsys_led_bank #(
        .NUM_CH   (NUM_CH),
        .WIDTH    (WIDTH),
        .RESET_VAL(9'h155),
        .BLINK_DIV(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] och(input int c);
        return out_port[c*WIDTH +: WIDTH];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write_n    = 1'b1;
        bus.byteenable = 4'hF;
        bus.writedata  = '0;
        bus.address    = '0;
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [1:0] rg,
                            input logic [3:0] be, input logic [31:0] wd);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.read       = 1'b0;
        bus.address    = {ch, rg};
        bus.byteenable = be;
        bus.writedata  = wd;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_read(input logic [1:0] ch, input logic [1:0] ra);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = {ch, ra};
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // k counts edges since the last edge that sampled reset low
    task automatic blink_run(input int last_k);
        logic [8:0] e;
        do_write(2'd3, 2'd0, 4'hF, 32'h0FF);
        do_write(2'd3, 2'd3, 4'hF, 32'h00F);
        for (int k = 2; k <= last_k; k++) begin
            if (k > 2) begin
                @(posedge clk); #1;
            end
            e = (((k / 4) % 2) == 1) ? 9'h0F0 : 9'h0FF;
            chk($sformatf("blink k=%0d", k), 64'(och(3)), 64'(e));
        end
    endtask

    initial begin
        tbl[0]  = '{2'd1, 2'd0, 4'hF, 32'h0000_00F0, 2'd0, 9'h0F0};
        tbl[1]  = '{2'd1, 2'd1, 4'hF, 32'h0000_0003, 2'd1, 9'h0F3};
        tbl[2]  = '{2'd1, 2'd2, 4'hF, 32'h0000_00F0, 2'd2, 9'h003};
        tbl[3]  = '{2'd0, 2'd0, 4'hF, 32'h0000_01FF, 2'd0, 9'h1FF};
        tbl[4]  = '{2'd0, 2'd0, 4'h1, 32'h0000_0000, 2'd1, 9'h100};
        tbl[5]  = '{2'd0, 2'd1, 4'h1, 32'h0000_0100, 2'd0, 9'h100};
        tbl[6]  = '{2'd2, 2'd0, 4'h2, 32'h0000_00AA, 2'd0, 9'h055};
        tbl[7]  = '{2'd3, 2'd2, 4'h2, 32'hFFFF_FFFF, 2'd0, 9'h055};
        tbl[8]  = '{2'd3, 2'd1, 4'hF, 32'hFFFF_FE00, 2'd2, 9'h055};
        tbl[9]  = '{2'd3, 2'd0, 4'hC, 32'hFFFF_FFFF, 2'd0, 9'h055};
        tbl[10] = '{2'd2, 2'd3, 4'hF, 32'h0000_01A5, 2'd3, 9'h1A5};
        tbl[11] = '{2'd2, 2'd3, 4'hF, 32'h0000_0000, 2'd3, 9'h000};
        pexp[0] = 9'h100;
        pexp[1] = 9'h003;
        pexp[2] = 9'h055;
        pexp[3] = 9'h055;

        idle();
        do_reset();
        chk("reset out_port", 64'(out_port), 64'({4{9'h155}}));
        chk("reset rvalid", 64'(bus.readdatavalid), 64'd0);
        chk("reset rdata", 64'(bus.readdata), 64'd0);

        do_read(2'd2, 2'd0);
        chk("rd ch2 valid", 64'(bus.readdatavalid), 64'd1);
        chk("rd ch2 data", 64'(bus.readdata), 64'h155);
        @(posedge clk); #1;
        chk("rd ch2 valid drop", 64'(bus.readdatavalid), 64'd0);
        chk("rd ch2 hold", 64'(bus.readdata), 64'h155);

        for (int i = 0; i < 12; i++) begin
            do_write(tbl[i].ch, tbl[i].rg, tbl[i].be, tbl[i].wd);
            if (tbl[i].rg != 2'd3)
                chk($sformatf("vec%0d out", i),
                    64'(och(int'(tbl[i].ch))), 64'(tbl[i].exp));
            do_read(tbl[i].ch, tbl[i].ra);
            chk($sformatf("vec%0d valid", i),
                64'(bus.readdatavalid), 64'd1);
            chk($sformatf("vec%0d rdata", i),
                64'(bus.readdata), 64'(tbl[i].exp));
        end

        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.address = {2'(c), 2'd0};
            @(posedge clk); #1;
            chk($sformatf("pipe%0d valid", c),
                64'(bus.readdatavalid), 64'd1);
            chk($sformatf("pipe%0d rdata", c),
                64'(bus.readdata), 64'(pexp[c]));
        end
        idle();
        @(posedge clk); #1;
        chk("pipe end valid", 64'(bus.readdatavalid), 64'd0);
        chk("pipe end hold", 64'(bus.readdata), 64'h055);

        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 4'h0;
        bus.writedata  = 32'h0AB;
        @(posedge clk); #1;
        idle();
        chk("rw valid", 64'(bus.readdatavalid), 64'd0);
        chk("rw out ch0", 64'(och(0)), 64'h0AB);
        chk("rw rdata hold", 64'(bus.readdata), 64'h055);

        do_reset();
        chk("reset2 rdata", 64'(bus.readdata), 64'd0);
        blink_run(13);
        do_read(2'd3, 2'd3);
        chk("blink mask valid", 64'(bus.readdatavalid), 64'd1);
        chk("blink mask rdata", 64'(bus.readdata), 64'h00F);

        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst valid", 64'(bus.readdatavalid), 64'd0);
        chk("midrst rdata", 64'(bus.readdata), 64'd0);
        chk("midrst out_port", 64'(out_port), 64'({4{9'h155}}));
        reset_n = 1'b1;
        blink_run(9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
